fp_mult_arbiter: RTL and testbench

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

---
 rtl/fp_mult_arbiter.sv | 109 ++++++++++
 tb/tb_fp_mult_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin arbiter sharing one fixed-latency FP multiplier among N_REQ requesters.
// A tag pipeline follows each issued op so results are routed back to their owner in issue order.
module fp_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 8
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*32-1:0]               req_a,
    input  logic [N_REQ*32-1:0]               req_b,
    input  logic                              hold,
    output logic                              m_a_tvalid,
    output logic                              m_b_tvalid,
    output logic [31:0]                       m_a_tdata,
    output logic [31:0]                       m_b_tdata,
    input  logic                              m_result_tvalid,
    input  logic [31:0]                       m_result_tdata,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [31:0]                       rsp_data,
    output logic [$clog2(LATENCY+2)-1:0]      inflight,
    output logic                              busy,
    output logic                              sync_error
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LATENCY + 2);

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      acc_idx;
    logic               accept;
    logic               tvalid_q, tvalid_d;
    logic [IW-1:0]      issue_idx_q, issue_idx_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [IW-1:0]      tag_i_q [LATENCY];
    logic [IW-1:0]      tag_i_d [LATENCY];
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               sync_error_q, sync_error_d;
    logic               out_v;
    logic [IW-1:0]      out_i;

    // Descending scan so the requester closest at/after rr_ptr is the last to overwrite acc_idx.
    always_comb begin
        req_ready = '0;
        acc_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % N_REQ]) acc_idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
        end
        accept = (|req_valid) && !hold && aresetn;
        if (accept) req_ready[acc_idx] = 1'b1;
    end

    assign out_v = tag_v_q[LATENCY-1];
    assign out_i = tag_i_q[LATENCY-1];

    always_comb begin
        rr_ptr_d     = accept ? ((acc_idx == IW'(N_REQ - 1)) ? '0 : acc_idx + 1'b1) : rr_ptr_q;
        tvalid_d     = accept;
        issue_idx_d  = accept ? acc_idx : issue_idx_q;
        a_d          = accept ? req_a[32*acc_idx +: 32] : a_q;
        b_d          = accept ? req_b[32*acc_idx +: 32] : b_q;
        // The issue register is the first hop; LATENCY further stages line up with the multiplier output.
        tag_v_d      = LATENCY'({tag_v_q, tvalid_q});
        tag_i_d[0]   = issue_idx_q;
        for (int k = 1; k < LATENCY; k++) tag_i_d[k] = tag_i_q[k-1];
        inflight_d   = inflight_q + CW'(accept) - CW'(out_v);
        sync_error_d = sync_error_q | (m_result_tvalid != out_v);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q     <= '0;
            tvalid_q     <= 1'b0;
            issue_idx_q  <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_v_q      <= '0;
            tag_i_q      <= '{default: '0};
            inflight_q   <= '0;
            sync_error_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tvalid_q     <= tvalid_d;
            issue_idx_q  <= issue_idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_v_q      <= tag_v_d;
            tag_i_q      <= tag_i_d;
            inflight_q   <= inflight_d;
            sync_error_q <= sync_error_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (m_result_tvalid && out_v) rsp_valid[out_i] = 1'b1;
    end

    assign rsp_data   = m_result_tdata;
    assign m_a_tvalid = tvalid_q;
    assign m_b_tvalid = tvalid_q;
    assign m_a_tdata  = a_q;
    assign m_b_tdata  = b_q;
    assign inflight   = inflight_q;
    assign busy       = (inflight_q != '0);
    assign sync_error = sync_error_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: random and directed stimulus against a queue-based model of the arbiter,
// with a behavioural fixed-latency multiplier attached to the shared port.
module tb_fp_mult_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [127:0]  req_a = '0;
    logic [127:0]  req_b = '0;
    logic          hold = 1'b0;
    logic          inj = 1'b0;
    logic          m_a_tvalid, m_b_tvalid;
    logic [31:0]   m_a_tdata, m_b_tdata;
    logic          m_result_tvalid;
    logic [31:0]   m_result_tdata;
    logic [NR-1:0] rsp_valid;
    logic [31:0]   rsp_data;
    logic [3:0]    inflight;
    logic          busy, sync_error;

    fp_mult_arbiter #(.N_REQ(NR), .LATENCY(LAT)) dut (
        .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .hold(hold),
        .m_a_tvalid(m_a_tvalid), .m_b_tvalid(m_b_tvalid), .m_a_tdata(m_a_tdata), .m_b_tdata(m_b_tdata),
        .m_result_tvalid(m_result_tvalid), .m_result_tdata(m_result_tdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .busy(busy),
        .sync_error(sync_error)
    );

    always #5 aclk = ~aclk;

    // Truncating single-precision multiply for normal operands.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {a[31] ^ b[31], 8'(e + 1), p[46:24]};
        return {a[31] ^ b[31], 8'(e), p[45:23]};
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'($urandom), 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
    endfunction

    logic [32:0] mpipe [LAT];
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) mpipe <= '{default: '0};
        else begin
            mpipe[0] <= {m_a_tvalid, fmul(m_a_tdata, m_b_tdata)};
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign m_result_tvalid = mpipe[LAT-1][32] | inj;
    assign m_result_tdata  = mpipe[LAT-1][31:0];

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } op_t;

    op_t         q[$];
    int          ptr, cyc, total, bad, peak;
    logic        acc_prev, sync_m;
    logic [31:0] exp_a, exp_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic [NR-1:0] er, erv;
        int            ei;
        er = '0;
        ei = 0;
        if (!hold)
            for (int k = 0; k < NR; k++)
                if (req_valid[(ptr + k) % NR] && er == '0) begin
                    ei = (ptr + k) % NR;
                    er[ei] = 1'b1;
                end
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        erv = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].idx] = 1'b1;
            chk("rsp_data", rsp_data, fmul(q[0].a, q[0].b));
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("m_a_tvalid", 32'(m_a_tvalid), 32'(acc_prev));
        chk("m_b_tvalid", 32'(m_b_tvalid), 32'(acc_prev));
        chk("m_a_tdata", m_a_tdata, exp_a);
        chk("m_b_tdata", m_b_tdata, exp_b);
        chk("rsp_valid", 32'(rsp_valid), 32'(erv));
        chk("inflight", 32'(inflight), 32'(q.size()));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("sync_error", 32'(sync_error), 32'(sync_m));
        acc_prev = (er != '0);
        if (er != '0) begin
            q.push_back('{idx: ei, a: req_a[32*ei +: 32], b: req_b[32*ei +: 32], due: cyc + LAT + 1});
            ptr   = (ei + 1) % NR;
            exp_a = req_a[32*ei +: 32];
            exp_b = req_b[32*ei +: 32];
        end
        if (inj) sync_m = 1'b1;
    endtask

    task automatic step(input logic [NR-1:0] v, input logic h, input logic in);
        @(posedge aclk);
        #1;
        req_valid = v;
        hold = h;
        inj = in;
        for (int i = 0; i < NR; i++) begin
            req_a[32*i +: 32] = rnd_op();
            req_b[32*i +: 32] = rnd_op();
        end
        @(negedge aclk);
        check_cycle();
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        req_valid = '1;
        hold = 1'b0;
        inj = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_m_a_tvalid", 32'(m_a_tvalid), 32'h0);
        chk("rst_m_b_tvalid", 32'(m_b_tvalid), 32'h0);
        chk("rst_m_a_tdata", m_a_tdata, 32'h0);
        chk("rst_m_b_tdata", m_b_tdata, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sync_error", 32'(sync_error), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        q.delete();
        ptr = 0;
        exp_a = '0;
        exp_b = '0;
        acc_prev = 1'b0;
        sync_m = 1'b0;
        @(posedge aclk);
        #1;
        req_valid = '0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        do_reset();

        // Single op from requester 2.
        @(posedge aclk);
        #1;
        req_valid = 4'b0100;
        req_a[95:64] = 32'h3F80_0000;
        req_b[95:64] = 32'h4000_0000;
        @(negedge aclk);
        chk("single_ready", 32'(req_ready), 32'h4);
        check_cycle();
        cyc++;
        step('0, 1'b0, 1'b0);
        chk("single_tvalid", 32'(m_a_tvalid), 32'h1);
        chk("single_tdata_a", m_a_tdata, 32'h3F80_0000);
        chk("single_tdata_b", m_b_tdata, 32'h4000_0000);
        for (int n = 2; n <= 9; n++) step('0, 1'b0, 1'b0);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_data", rsp_data, 32'h4000_0000);
        step('0, 1'b0, 1'b0);
        chk("single_drained", 32'(inflight), 32'h0);

        // All requesters continuously valid.
        do_reset();
        peak = 0;
        for (int k = 0; k < 20; k++) begin
            step('1, 1'b0, 1'b0);
            if (k < 8) chk("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
            if (int'(inflight) > peak) peak = int'(inflight);
            if (k >= 10) chk("steady_inflight", 32'(inflight), 32'd9);
        end
        chk("inflight_peak", 32'(peak), 32'd9);
        for (int n = 1; n <= 11; n++) begin
            step('0, 1'b0, 1'b0);
            if (n == 9) chk("drain_last", 32'(inflight), 32'd1);
            if (n == 10) begin
                chk("drain_zero", 32'(inflight), 32'd0);
                chk("drain_busy", 32'(busy), 32'd0);
            end
        end

        // Hold blocks grants while issued ops still return.
        for (int k = 0; k < 3; k++) step('1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step('1, 1'b1, 1'b0);
            chk("hold_ready", 32'(req_ready), 32'h0);
        end
        step('1, 1'b0, 1'b0);
        chk("hold_resume", 32'(req_ready), 32'h8);

        // Random traffic.
        for (int k = 0; k < 1500; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 1'b0);

        // Spurious result with nothing in flight.
        for (int k = 0; k < 12; k++) step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        chk("spurious_rsp", 32'(rsp_valid), 32'h0);
        step('0, 1'b0, 1'b0);
        chk("spurious_sticky", 32'(sync_error), 32'h1);
        for (int k = 0; k < 20; k++) step(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        chk("spurious_still", 32'(sync_error), 32'h1);

        // Reset with five ops in flight.
        do_reset();
        for (int k = 0; k < 5; k++) step('1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        chk("five_inflight", 32'(inflight), 32'd5);
        do_reset();
        step('1, 1'b0, 1'b0);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        for (int k = 0; k < 12; k++) step(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        do_reset();
        step(4'b0110, 1'b0, 1'b0);
        chk("post_rst_lowest", 32'(req_ready), 32'h2);
        for (int k = 0; k < 200; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 1'b0);
        for (int k = 0; k < 12; k++) step('0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
